// File: rtl/pix_axis_packer.sv
// pix_axis_packer: frames a camera pixel stream as AXI4-Stream video through a first-word-fall-through FIFO.
// Define PIX_AXIS_STATS_EN to add the oFRAME_CNT / oDROP_CNT statistics ports.
module pix_axis_packer #(
  parameter int DATA_W     = 24,
  parameter int H_ACTIVE   = 1280,
  parameter int V_ACTIVE   = 720,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [DATA_W-1:0] iDATA,
  input  logic              iDVAL,
  input  logic              iSYNC,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tuser,
  output logic              m_axis_tlast,
  output logic              oOVF,
  output logic              oSHORT
`ifdef PIX_AXIS_STATS_EN
  ,
  output logic [15:0]       oFRAME_CNT,
  output logic [15:0]       oDROP_CNT
`endif
);
  localparam int CW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int RW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = DATA_W + 2;
  localparam logic [CW-1:0] COL_MAX = CW'(H_ACTIVE - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(V_ACTIVE - 1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(FIFO_DEPTH);
  localparam logic [1:0] S_WAIT = 2'd0, S_ACTIVE = 2'd1, S_DROP = 2'd2;

  logic [1:0]    r_state;
  logic          r_sync_d;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [EW-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_cnt;
  logic          r_ovf, r_short;

  logic          w_rise, w_empty, w_full, w_pop, w_take, w_wr, w_ovf;
  logic          w_eol, w_eof, w_sof, w_trunc;
  logic [CW-1:0] w_col;
  logic [RW-1:0] w_row;
  logic [1:0]    w_nstate;
  logic [EW-1:0] w_head;

  // A sync edge restarts the frame in the same cycle, so a coincident pixel is pixel 0.
  always_comb begin
    w_rise   = iSYNC & ~r_sync_d;
    w_empty  = r_cnt == '0;
    w_full   = r_cnt == CNT_FULL;
    w_pop    = ~w_empty & m_axis_tready;
    w_take   = iDVAL & (w_rise | (r_state == S_ACTIVE));
    w_col    = w_rise ? '0 : r_col;
    w_row    = w_rise ? '0 : r_row;
    w_sof    = (w_col == '0) && (w_row == '0);
    w_eol    = w_col == COL_MAX;
    w_eof    = w_eol && (w_row == ROW_MAX);
    w_wr     = w_take & (~w_full | w_pop);
    w_ovf    = w_take & w_full & ~w_pop;
    w_trunc  = w_rise & (r_state == S_ACTIVE) & ((r_col != '0) | (r_row != '0));
    w_nstate = w_ovf ? S_DROP : (w_wr & w_eof) ? S_WAIT : w_rise ? S_ACTIVE : r_state;
    w_head   = r_mem[r_rptr];
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_state  <= S_WAIT;
      r_sync_d <= 1'b0;
      r_col    <= '0;
      r_row    <= '0;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_cnt    <= '0;
      r_ovf    <= 1'b0;
      r_short  <= 1'b0;
    end else begin
      r_state  <= w_nstate;
      r_sync_d <= iSYNC;
      if (w_wr) begin
        r_col <= w_eol ? '0 : w_col + 1'b1;
        r_row <= w_eof ? '0 : w_eol ? w_row + 1'b1 : w_row;
      end else if (w_rise) begin
        r_col <= '0;
        r_row <= '0;
      end
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      r_cnt <= r_cnt + {{AW{1'b0}}, w_wr} - {{AW{1'b0}}, w_pop};
      if (w_ovf) r_ovf <= 1'b1;
      if (w_trunc) r_short <= 1'b1;
    end
  end

  always_ff @(posedge iCLK) begin
    if (w_wr) r_mem[r_wptr] <= {w_sof, w_eol, iDATA};
  end

  // Head entry is gated so every output reads 0 while the FIFO is empty.
  assign m_axis_tvalid = ~w_empty;
  assign m_axis_tdata  = w_empty ? '0 : w_head[DATA_W-1:0];
  assign m_axis_tuser  = ~w_empty & w_head[DATA_W+1];
  assign m_axis_tlast  = ~w_empty & w_head[DATA_W];
  assign oOVF          = r_ovf;
  assign oSHORT        = r_short;

`ifdef PIX_AXIS_STATS_EN
  logic [15:0] r_frames, r_drops;
  logic        w_drop;

  assign w_drop = w_ovf | (iDVAL & ~w_rise & (r_state == S_DROP));

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_frames <= '0;
      r_drops  <= '0;
    end else begin
      if (w_wr & w_eof) r_frames <= r_frames + 1'b1;
      if (w_drop && r_drops != 16'hFFFF) r_drops <= r_drops + 1'b1;
    end
  end

  assign oFRAME_CNT = r_frames;
  assign oDROP_CNT  = r_drops;
`endif
endmodule
